// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: result classes, IEEE-754 single field
// positions, sticky flag bit positions and the result-buffer entry layout.
package fpu_pkg;

   typedef enum logic [2:0] {
      FP_ZERO      = 3'd0,
      FP_SUBNORMAL = 3'd1,
      FP_NORMAL    = 3'd2,
      FP_INF       = 3'd3,
      FP_QNAN      = 3'd4,
      FP_SNAN      = 3'd5
   } fp_class_e;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MAN_MSB  = 22;
   localparam int QNAN_BIT = 22;

   localparam int FLG_OVR = 3;
   localparam int FLG_NAN = 2;
   localparam int FLG_INF = 1;
   localparam int FLG_SUB = 0;

   // One queued result together with its precomputed class and sign.
   typedef struct packed {
      logic [31:0] result;
      fp_class_e   cls;
      logic        sign;
   } fp_entry_t;

   localparam fp_entry_t ENTRY_RESET = '{result: 32'h0000_0000, cls: FP_ZERO, sign: 1'b0};

endpackage

// File: rtl/fpu_result_buffer_if.sv
// Result stream handshake: producer side (in_valid/in_result, never stalled)
// and consumer side (out_valid/out_ready with head result, class and sign).
interface fpu_result_buffer_if;

   logic                    in_valid;
   logic [31:0]             in_result;
   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             out_result;
   fpu_pkg::fp_class_e      out_class;
   logic                    out_sign;

   // Environment side: drives results in and accepts entries out.
   modport master (
      output in_valid,
      output in_result,
      output out_ready,
      input  out_valid,
      input  out_result,
      input  out_class,
      input  out_sign
   );

   // Buffer side.
   modport slave (
      input  in_valid,
      input  in_result,
      input  out_ready,
      output out_valid,
      output out_result,
      output out_class,
      output out_sign
   );

endinterface

// File: rtl/fpu_classify.sv
// Combinational IEEE-754 single-precision classifier. Kept standalone so
// the multiply and divide stages can reuse it.
module fpu_classify
   import fpu_pkg::*;
(
   input  logic [31:0] value,
   output fp_class_e   cls,
   output logic        sign
);

   logic [EXP_MSB-EXP_LSB:0] exp_s;
   logic [MAN_MSB:0]         man_s;

   // Split the word into exponent and mantissa fields and decode the class.
   always_comb begin
      exp_s = value[EXP_MSB:EXP_LSB];
      man_s = value[MAN_MSB:0];
      sign  = value[SIGN_BIT];
      cls   = FP_NORMAL;
      if (exp_s == 8'h00) begin
         if (man_s == 23'd0) begin
            cls = FP_ZERO;
         end else begin
            cls = FP_SUBNORMAL;
         end
      end else if (exp_s == 8'hFF) begin
         if (man_s == 23'd0) begin
            cls = FP_INF;
         end else if (man_s[QNAN_BIT]) begin
            cls = FP_QNAN;
         end else begin
            cls = FP_SNAN;
         end
      end else begin
         cls = FP_NORMAL;
      end
   end

endmodule

// File: rtl/fpu_result_buffer.sv
// Result buffer behind the add/sub core. The core cannot be stalled, so
// every result is classified and queued here; when the queue is full and
// nothing drains, the result is lost and the loss is recorded in sticky
// flags and a saturating drop counter.
module fpu_result_buffer
   import fpu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                   clk,
   input  logic                   arst,
   fpu_result_buffer_if.slave     bus,
   output logic [$clog2(DEPTH):0] level,
   output logic [3:0]             flags,
   input  logic                   flags_clr,
   output logic [DROP_W-1:0]      drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   fp_entry_t          mem_r [DEPTH];
   logic [PW-1:0]      wr_ptr_r;
   logic [PW-1:0]      rd_ptr_r;
   logic [PW-1:0]      level_r;
   logic [3:0]         flags_r;
   logic [DROP_W-1:0]  drop_cnt_r;

   fp_class_e          in_cls_s;
   logic               in_sign_s;
   logic               empty_s;
   logic               full_s;
   logic               pop_s;
   logic               push_s;
   logic               drop_s;
   logic [3:0]         flag_set_s;
   fp_entry_t          head_s;

   fpu_classify u_classify (
      .value (bus.in_result),
      .cls   (in_cls_s),
      .sign  (in_sign_s)
   );

   // Queue status and the push/pop/drop decisions for this cycle.
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
      pop_s   = !empty_s && bus.out_ready;
      // A full queue still takes the new result when the head leaves this cycle.
      push_s  = bus.in_valid && (!full_s || pop_s);
      drop_s  = bus.in_valid && full_s && !pop_s;
   end

   // Sticky-flag set events; every valid result counts, queued or dropped.
   always_comb begin
      flag_set_s = 4'b0000;
      if (bus.in_valid) begin
         flag_set_s[FLG_OVR] = drop_s;
         flag_set_s[FLG_NAN] = (in_cls_s == FP_QNAN) || (in_cls_s == FP_SNAN);
         flag_set_s[FLG_INF] = (in_cls_s == FP_INF);
         flag_set_s[FLG_SUB] = (in_cls_s == FP_SUBNORMAL);
      end else begin
         flag_set_s = 4'b0000;
      end
   end

   // Read/write pointers (extra wrap bit) and occupancy counter.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         level_r  <= {PW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + PW'(1);
            2'b01:   level_r <= level_r - PW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head never reads as X.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= ENTRY_RESET;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= '{result: bus.in_result, cls: in_cls_s, sign: in_sign_s};
      end
   end

   // Sticky flags and drop counter; a set event in the clear cycle survives.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         flags_r    <= 4'b0000;
         drop_cnt_r <= {DROP_W{1'b0}};
      end else if (flags_clr) begin
         flags_r    <= flag_set_s;
         drop_cnt_r <= drop_s ? DROP_W'(1) : {DROP_W{1'b0}};
      end else begin
         flags_r <= flags_r | flag_set_s;
         if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_W'(1);
         end
      end
   end

   // Head entry selection straight from the storage registers.
   always_comb begin
      head_s = mem_r[rd_ptr_r[AW-1:0]];
   end

   assign bus.out_valid  = !empty_s;
   assign bus.out_result = head_s.result;
   assign bus.out_class  = head_s.cls;
   assign bus.out_sign   = head_s.sign;
   assign level          = level_r;
   assign flags          = flags_r;
   assign drop_count     = drop_cnt_r;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Self-checking bench for fpu_result_buffer: scenario tasks with a
// scoreboard queue of hand-classified expected entries.
module tb_fpu_result_buffer;
   import fpu_pkg::*;

   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;
   localparam int LW     = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] result;
      logic [2:0]  cls;
      logic        sign;
   } exp_t;

   logic              clk = 1'b0;
   logic              arst;
   logic              flags_clr;
   logic [LW-1:0]     level;
   logic [3:0]        flags;
   logic [DROP_W-1:0] drop_count;

   fpu_result_buffer_if bus ();

   fpu_result_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk        (clk),
      .arst       (arst),
      .bus        (bus),
      .level      (level),
      .flags      (flags),
      .flags_clr  (flags_clr),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   exp_t       sb_q[$];
   logic [3:0] m_flags;
   int         m_drops;
   logic [2:0] drv_cls;
   logic       drv_sign;

   task automatic drive(input logic valid, input logic [31:0] val, input logic [2:0] cls, input logic sgn);
      bus.in_valid  = valid;
      bus.in_result = val;
      drv_cls       = cls;
      drv_sign      = sgn;
   endtask

   // Advance the model by one clock using current inputs, then step the DUT.
   task automatic clock_cycle();
      bit         m_pop;
      bit         m_push;
      bit         m_drop;
      logic [3:0] set_v;
      m_pop  = (sb_q.size() > 0) && bus.out_ready;
      m_push = bus.in_valid && ((sb_q.size() < DEPTH) || m_pop);
      m_drop = bus.in_valid && !m_push;
      set_v  = 4'b0000;
      if (bus.in_valid) begin
         set_v[3] = m_drop;
         set_v[2] = (drv_cls == 3'd4) || (drv_cls == 3'd5);
         set_v[1] = (drv_cls == 3'd3);
         set_v[0] = (drv_cls == 3'd1);
      end
      if (flags_clr) begin
         m_flags = set_v;
         m_drops = m_drop ? 1 : 0;
      end else begin
         m_flags = m_flags | set_v;
         if (m_drop && m_drops < 255) m_drops++;
      end
      if (m_pop) sb_q.delete(0);
      if (m_push) sb_q.push_back('{bus.in_result, drv_cls, drv_sign});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst = 1'b1; flags_clr = 1'b0; bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      sb_q.delete(); m_flags = 4'b0; m_drops = 0;
      #3;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drops got %0d exp 0", drop_count); end
      checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.out_result); end
      checks++; if (bus.out_class !== FP_ZERO || bus.out_sign !== 1'b0) begin
         errors++; $display("FAIL reset_class got %0d/%b exp 0/0", bus.out_class, bus.out_sign); end
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic test_single();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h41700000, 3'd2, 1'b0);
      clock_cycle();
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_result !== 32'h41700000) begin errors++; $display("FAIL single_result got %h exp 41700000", bus.out_result); end
      checks++; if (bus.out_class !== FP_NORMAL || bus.out_sign !== 1'b0) begin
         errors++; $display("FAIL single_class got %0d/%b exp 2/0", bus.out_class, bus.out_sign); end
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL single_flags got %b exp 0000", flags); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH && sb_q.size() > 0; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_class, bus.out_sign} !== sb_q[0]) begin
            errors++; $display("FAIL single_drain got %h/%0d/%b exp %h/%0d/%b", bus.out_result, bus.out_class,
                               bus.out_sign, sb_q[0].result, sb_q[0].cls, sb_q[0].sign); end
         clock_cycle();
      end
      checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
         errors++; $display("FAIL single_empty got valid %b level %0d exp 0/0", bus.out_valid, level); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4] = '{32'h80000000, 32'h00400000, 32'hFF800000, 32'h7FA00000};
      logic [2:0]  clss [4] = '{3'd0, 3'd1, 3'd3, 3'd5};
      logic        sgns [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vals[i], clss[i], sgns[i]);
         clock_cycle();
      end
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level got %0d exp 4", level); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH && sb_q.size() > 0; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_class, bus.out_sign} !== sb_q[0]) begin
            errors++; $display("FAIL b2b_drain got %h/%0d/%b exp %h/%0d/%b", bus.out_result, bus.out_class,
                               bus.out_sign, sb_q[0].result, sb_q[0].cls, sb_q[0].sign); end
         clock_cycle();
      end
      checks++; if (flags !== 4'b0111) begin errors++; $display("FAIL b2b_flags got %b exp 0111", flags); end
      checks++; if (sb_q.size() != 0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_empty got valid %b left %0d exp 0/0", bus.out_valid, sb_q.size()); end
   endtask

   task automatic test_overrun();
      logic [31:0] vals [4] = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'hBF000000};
      logic        sgns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vals[i], 3'd2, sgns[i]);
         clock_cycle();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h7FC00000, 3'd4, 1'b0);
         clock_cycle();
      end
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovr_level got %0d exp 4", level); end
      checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL ovr_drops got %0d exp 2", drop_count); end
      checks++; if (flags[3] !== 1'b1 || flags[2] !== 1'b1) begin errors++; $display("FAIL ovr_flags got %b exp 11xx", flags); end
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL ovr_flags_model got %b exp %b", flags, m_flags); end
      checks++; if (bus.out_result !== 32'h3F800000) begin errors++; $display("FAIL ovr_head got %h exp 3F800000", bus.out_result); end
   endtask

   task automatic test_full_pop();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h40A00000, 3'd2, 1'b0);
      checks++;
      if ({bus.out_result, bus.out_class, bus.out_sign} !== sb_q[0]) begin
         errors++; $display("FAIL fullpop_head got %h exp %h", bus.out_result, sb_q[0].result); end
      clock_cycle();
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d exp 4", level); end
      checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL fullpop_drops got %0d exp 2", drop_count); end
      for (int i = 0; i < DEPTH && sb_q.size() > 0; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_class, bus.out_sign} !== sb_q[0]) begin
            errors++; $display("FAIL fullpop_drain got %h/%0d/%b exp %h/%0d/%b", bus.out_result, bus.out_class,
                               bus.out_sign, sb_q[0].result, sb_q[0].cls, sb_q[0].sign); end
         if (i == 3) begin
            checks++; if (bus.out_result !== 32'h40A00000) begin errors++; $display("FAIL fullpop_fourth got %h exp 40A00000", bus.out_result); end
         end
         clock_cycle();
      end
   endtask

   task automatic test_clear();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h3F800000 + i, 3'd2, 1'b0);
         clock_cycle();
      end
      flags_clr = 1'b1;
      drive(1'b1, 32'h41200000, 3'd2, 1'b0);
      clock_cycle();
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL clr_set_wins got %b exp 1000", flags); end
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL clr_drop_one got %0d exp 1", drop_count); end
      clock_cycle();
      flags_clr = 1'b0;
      checks++; if (flags !== 4'b0000 || drop_count !== 8'd0) begin
         errors++; $display("FAIL clr_alone got %b/%0d exp 0000/0", flags, drop_count); end
   endtask

   task automatic test_saturate();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h7F800000, 3'd3, 1'b0);
      for (int i = 0; i < 260; i++) clock_cycle();
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (drop_count !== 8'hFF) begin errors++; $display("FAIL sat_drops got %0d exp 255", drop_count); end
      checks++; if (flags !== 4'b1010 || flags !== m_flags) begin errors++; $display("FAIL sat_flags got %b exp 1010", flags); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH && sb_q.size() > 0; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || {bus.out_result, bus.out_class, bus.out_sign} !== sb_q[0]) begin
            errors++; $display("FAIL sat_drain got %h/%0d/%b exp %h/%0d/%b", bus.out_result, bus.out_class,
                               bus.out_sign, sb_q[0].result, sb_q[0].cls, sb_q[0].sign); end
         clock_cycle();
      end
      checks++; if (level !== 3'd0 || drop_count !== 8'hFF) begin
         errors++; $display("FAIL sat_after got level %0d drops %0d exp 0/255", level, drop_count); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hC1000000 + i, 3'd2, 1'b1);
         clock_cycle();
      end
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (level !== 3'd3) begin errors++; $display("FAIL arst_prelevel got %0d exp 3", level); end
      #2;
      arst = 1'b1;
      sb_q.delete(); m_flags = 4'b0; m_drops = 0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
         errors++; $display("FAIL arst_immediate got valid %b level %0d exp 0/0", bus.out_valid, level); end
      checks++; if (bus.out_result !== 32'h0 || drop_count !== 8'd0 || flags !== 4'b0) begin
         errors++; $display("FAIL arst_clear got %h/%0d/%b exp 0/0/0", bus.out_result, drop_count, flags); end
      #3;
      arst = 1'b0;
      drive(1'b1, 32'h3F800000, 3'd2, 1'b0);
      clock_cycle();
      drive(1'b0, 32'h0, 3'd0, 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3F800000 || level !== 3'd1) begin
         errors++; $display("FAIL arst_repush got valid %b %h level %0d exp 1 3F800000 1", bus.out_valid, bus.out_result, level); end
      bus.out_ready = 1'b1;
      checks++;
      if ({bus.out_result, bus.out_class, bus.out_sign} !== sb_q[0]) begin
         errors++; $display("FAIL arst_drain got %h exp %h", bus.out_result, sb_q[0].result); end
      clock_cycle();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_final got %b exp 0", bus.out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_full_pop();
      test_clear();
      test_saturate();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
